// File: rtl/mem_block_copier.sv
// Overlap-safe (memmove) block copier driving a 1W/1R-combinational word memory.
// Optional COPY_CHECKSUM_EN adds a mod-2^DATA_WIDTH sum of all written words.
module mem_block_copier #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] Src_Address,
  input  logic [ADDR_WIDTH-1:0] Dst_Address,
  input  logic [ADDR_WIDTH-1:0] Length,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Mem_Write_Enable,
  output logic [ADDR_WIDTH-1:0] Mem_Write_Address,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data,
  output logic [ADDR_WIDTH-1:0] Mem_Read_Address,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data
`ifdef COPY_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] Checksum
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q, cnt_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  desc_q, busy_q, done_q, we_q;

  logic [ADDR_WIDTH-1:0] diff_d, src_start_d, dst_start_d, step_d;
  logic                  desc_d;

  // Copy backwards only when the destination starts inside the source block.
  always_comb begin
    diff_d      = Dst_Address - Src_Address;
    desc_d      = (diff_d != '0) && (diff_d < Length);
    src_start_d = desc_d ? (Src_Address + Length - ONE) : Src_Address;
    dst_start_d = desc_d ? (Dst_Address + Length - ONE) : Dst_Address;
    step_d      = desc_q ? '1 : ONE;
  end

`ifdef COPY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;
  assign Checksum = sum_q;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      desc_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
`ifdef COPY_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            src_q  <= src_start_d;
            dst_q  <= dst_start_d;
            cnt_q  <= Length;
            desc_q <= desc_d;
`ifdef COPY_CHECKSUM_EN
            sum_q  <= '0;
`endif
            if (Length == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= READ;
              busy_q  <= 1'b1;
            end
          end
        end
        READ: begin
          data_q  <= Mem_Read_Data;
          we_q    <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: begin
          we_q  <= 1'b0;
          src_q <= src_q + step_d;
          dst_q <= dst_q + step_d;
          cnt_q <= cnt_q - ONE;
`ifdef COPY_CHECKSUM_EN
          sum_q <= sum_q + data_q;
`endif
          if (cnt_q == ONE) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= READ;
          end
        end
        DONE: begin
          // Done is registered out of DONE, so it is seen the cycle after.
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy              = busy_q;
  assign Done              = done_q;
  assign Mem_Write_Enable  = we_q;
  assign Mem_Write_Address = dst_q;
  assign Mem_Write_Data    = data_q;
  assign Mem_Read_Address  = src_q;

endmodule

// File: tb/tb_mem_block_copier.sv
// Directed self-checking bench for mem_block_copier with a behavioural 64K-word memory.
module tb_mem_block_copier;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] Src_Address = '0, Dst_Address = '0, Length = '0;
  logic        Busy, Done, Mem_Write_Enable;
  logic [15:0] Mem_Write_Address, Mem_Write_Data, Mem_Read_Address, Mem_Read_Data;
`ifdef COPY_CHECKSUM_EN
  logic [15:0] Checksum;
`endif

  mem_block_copier #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .Src_Address(Src_Address), .Dst_Address(Dst_Address), .Length(Length),
    .Busy(Busy), .Done(Done), .Mem_Write_Enable(Mem_Write_Enable),
    .Mem_Write_Address(Mem_Write_Address), .Mem_Write_Data(Mem_Write_Data),
    .Mem_Read_Address(Mem_Read_Address), .Mem_Read_Data(Mem_Read_Data)
`ifdef COPY_CHECKSUM_EN
    , .Checksum(Checksum)
`endif
  );

  always #5 Clock = ~Clock;

  logic [15:0] mem [0:65535];
  logic [15:0] wr_log [0:255];
  int          wr_n = 0;
  logic        pl_we = 1'b0;
  logic [15:0] pl_addr = '0, pl_data = '0;

  assign Mem_Read_Data = mem[Mem_Read_Address];

  always @(posedge Clock) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (Mem_Write_Enable) begin
      mem[Mem_Write_Address] <= Mem_Write_Data;
      wr_log[wr_n[7:0]]      <= Mem_Write_Address;
      wr_n                   <= wr_n + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    tick();
    pl_we   = 1'b0;
  endtask

  // Start at edge 0, then watch a bounded window recording Done edge, Busy cycles, Done cycles.
  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input int l,
                          output int done_edge, output int busy_cyc, output int done_cyc);
    Src_Address = s;
    Dst_Address = d;
    Length      = 16'(l);
    Start       = 1'b1;
    tick();
    Start       = 1'b0;
    Src_Address = 16'hDEAD;
    Dst_Address = 16'hBEEF;
    Length      = 16'h0007;
    done_edge   = -1;
    busy_cyc    = Busy ? 1 : 0;
    done_cyc    = Done ? 1 : 0;
    for (int k = 1; k <= 2 * l + 6; k++) begin
      tick();
      if (Busy) busy_cyc++;
      if (Done) begin
        done_cyc++;
        if (done_edge < 0) done_edge = k;
      end
    end
  endtask

  int de, bc, dc, w0;
  int busy_seen, done_seen, we_seen;
  logic [15:0] vals [0:3];

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_we", 32'(Mem_Write_Enable), 32'd0);
    check("rst_waddr", 32'(Mem_Write_Address), 32'h0);
    check("rst_wdata", 32'(Mem_Write_Data), 32'h0);
    check("rst_raddr", 32'(Mem_Read_Address), 32'h0);
`ifdef COPY_CHECKSUM_EN
    check("rst_chk", 32'(Checksum), 32'h0);
`endif
    Reset = 1'b0;

    // Basic ascending copy
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
    for (int i = 0; i < 4; i++) poke(16'h0100 + 16'(i), vals[i]);
    w0 = wr_n;
    run_copy(16'h0100, 16'h0200, 4, de, bc, dc);
    check("basic_done_edge", 32'(de), 32'd9);
    check("basic_busy_cycles", 32'(bc), 32'd8);
    check("basic_done_cycles", 32'(dc), 32'd1);
    check("basic_writes", 32'(wr_n - w0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("basic_waddr", 32'(wr_log[w0 + i]), 32'h0200 + 32'(i));
      check("basic_data", 32'(mem[16'h0200 + 16'(i)]), 32'(vals[i]));
    end
`ifdef COPY_CHECKSUM_EN
    check("basic_chk", 32'(Checksum), 32'hAAAA);
`endif

    // Overlapping forward copy goes descending
    vals[0] = 16'hA0A0; vals[1] = 16'hB0B0; vals[2] = 16'hC0C0; vals[3] = 16'hD0D0;
    for (int i = 0; i < 4; i++) poke(16'h0010 + 16'(i), vals[i]);
    w0 = wr_n;
    run_copy(16'h0010, 16'h0012, 4, de, bc, dc);
    check("ovl_done_edge", 32'(de), 32'd9);
    check("ovl_writes", 32'(wr_n - w0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("ovl_waddr", 32'(wr_log[w0 + i]), 32'h0015 - 32'(i));
      check("ovl_data", 32'(mem[16'h0012 + 16'(i)]), 32'(vals[i]));
    end

    // Length 0
    w0 = wr_n;
    run_copy(16'h0000, 16'h0005, 0, de, bc, dc);
    check("len0_done_edge", 32'(de), 32'd1);
    check("len0_busy_cycles", 32'(bc), 32'd0);
    check("len0_done_cycles", 32'(dc), 32'd1);
    check("len0_writes", 32'(wr_n - w0), 32'd0);

    // Ascending source wrap
    vals[0] = 16'hE001; vals[1] = 16'hE002; vals[2] = 16'hE003; vals[3] = 16'hE004;
    poke(16'hFFFE, vals[0]); poke(16'hFFFF, vals[1]);
    poke(16'h0000, vals[2]); poke(16'h0001, vals[3]);
    w0 = wr_n;
    run_copy(16'hFFFE, 16'h0020, 4, de, bc, dc);
    check("wrap_writes", 32'(wr_n - w0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("wrap_waddr", 32'(wr_log[w0 + i]), 32'h0020 + 32'(i));
      check("wrap_data", 32'(mem[16'h0020 + 16'(i)]), 32'(vals[i]));
    end

    // Descending copy whose pointers cross 0x0000 -> 0xFFFF
    poke(16'hFFFF, 16'h7A7A);
    poke(16'h0000, 16'h7B7B);
    w0 = wr_n;
    run_copy(16'hFFFF, 16'h0000, 2, de, bc, dc);
    check("dwrap_waddr0", 32'(wr_log[w0]), 32'h0001);
    check("dwrap_waddr1", 32'(wr_log[w0 + 1]), 32'h0000);
    check("dwrap_m0", 32'(mem[16'h0000]), 32'h7A7A);
    check("dwrap_m1", 32'(mem[16'h0001]), 32'h7B7B);

    // Src == Dst rewrites in place, ascending
    poke(16'h0300, 16'h5150);
    poke(16'h0301, 16'h5151);
    w0 = wr_n;
    run_copy(16'h0300, 16'h0300, 2, de, bc, dc);
    check("same_writes", 32'(wr_n - w0), 32'd2);
    check("same_waddr0", 32'(wr_log[w0]), 32'h0300);
    check("same_waddr1", 32'(wr_log[w0 + 1]), 32'h0301);
    check("same_m1", 32'(mem[16'h0301]), 32'h5151);

    // Extra Start mid-copy, then Reset after the second write
    for (int i = 0; i < 5; i++) begin
      poke(16'h0400 + 16'(i), 16'h6600 + 16'(i));
      poke(16'h0500 + 16'(i), 16'h0000);
    end
    w0 = wr_n;
    Src_Address = 16'h0400; Dst_Address = 16'h0500; Length = 16'd5;
    Start = 1'b1;
    tick();                      // edge 0: accepted
    Start = 1'b0;
    tick();                      // edge 1: now in WRITE
    Src_Address = 16'h0000; Dst_Address = 16'h0600; Length = 16'd1;
    Start = 1'b1;
    tick();                      // edge 2: first write lands; Start must be ignored
    Start = 1'b0;
    tick();                      // edge 3
    tick();                      // edge 4: second write lands
    Reset = 1'b1;
    tick();                      // edge 5
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_done", 32'(Done), 32'd0);
    check("mid_rst_we", 32'(Mem_Write_Enable), 32'd0);
    check("mid_rst_waddr", 32'(Mem_Write_Address), 32'h0);
    check("mid_rst_raddr", 32'(Mem_Read_Address), 32'h0);
    Reset = 1'b0;
    busy_seen = 0; done_seen = 0; we_seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (Busy) busy_seen++;
      if (Done) done_seen++;
      if (Mem_Write_Enable) we_seen++;
    end
    check("mid_no_done", 32'(done_seen), 32'd0);
    check("mid_no_busy", 32'(busy_seen), 32'd0);
    check("mid_no_we", 32'(we_seen), 32'd0);
    check("mid_writes", 32'(wr_n - w0), 32'd2);
    check("mid_m0", 32'(mem[16'h0500]), 32'h6600);
    check("mid_m1", 32'(mem[16'h0501]), 32'h6601);
    check("mid_m2", 32'(mem[16'h0502]), 32'h0000);
    check("mid_m4", 32'(mem[16'h0504]), 32'h0000);

    // Start held high through DONE relaunches only from IDLE
    poke(16'h0800, 16'h1234);
    w0 = wr_n;
    Src_Address = 16'h0800; Dst_Address = 16'h0810; Length = 16'd1;
    Start = 1'b1;
    tick();                      // edge 0
    tick();                      // edge 1: WRITE
    tick();                      // edge 2: DONE state
    check("hold_busy_e2", 32'(Busy), 32'd0);
    tick();                      // edge 3: Done out, back in IDLE
    check("hold_done_e3", 32'(Done), 32'd1);
    check("hold_busy_e3", 32'(Busy), 32'd0);
    tick();                      // edge 4: relaunch
    check("hold_busy_e4", 32'(Busy), 32'd1);
    Start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("hold_writes", 32'(wr_n - w0), 32'd2);
    check("hold_data", 32'(mem[16'h0810]), 32'h1234);

`ifdef COPY_CHECKSUM_EN
    poke(16'h0700, 16'h8000);
    poke(16'h0701, 16'h8001);
    run_copy(16'h0700, 16'h0710, 2, de, bc, dc);
    check("chk_sum", 32'(Checksum), 32'h0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
